// File: rtl/tgm_pkg.sv
// Shared widths and state encoding for the TGM output RAM sequencer.
package tgm_pkg;

  localparam int TGM_ADDR_W    = 8;
  localparam int TGM_RAM_DEPTH = 256;
  localparam int TGM_WORD_W    = 32;
  localparam int TGM_BYTE_W    = 8;
  // One extra bit so a full 256-entry frame count is representable.
  localparam int TGM_PTR_W     = TGM_ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    OUT     = 3'd4,
    DONE    = 3'd5
  } tgm_state_t;

  // RAM address of frame element ptr; the sum wraps modulo the RAM depth.
  function automatic logic [TGM_ADDR_W-1:0] tgm_addr(
      input logic [TGM_ADDR_W-1:0] base,
      input logic [TGM_PTR_W-1:0]  ptr
  );
    return base + ptr[TGM_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/tgm_addr_ctr.sv
// Clearable / incrementing frame pointer with a base-offset RAM address.
// clr has priority over inc; addr is a pure decode of the current pointer.
module tgm_addr_ctr
  import tgm_pkg::*;
#(
  parameter logic [TGM_ADDR_W-1:0] BASE_ADDR = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  output logic [TGM_PTR_W-1:0]  ptr,
  output logic [TGM_ADDR_W-1:0] addr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

  assign addr = tgm_addr(BASE_ADDR, ptr);

endmodule

// File: rtl/tgm_ram_seq.sv
// Fills the TGM output RAM with one byte frame, then streams it back word by word.
// Read path: strobe, one wait cycle for the registered RAM, then hold until downstream takes it.
module tgm_ram_seq
  import tgm_pkg::*;
#(
  parameter int                    FRAME_LEN = 16,
  parameter logic [TGM_ADDR_W-1:0] BASE_ADDR = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TGM_BYTE_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TGM_WORD_W-1:0] out_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  ram_wr,
  output logic                  ram_rd,
  output logic [TGM_ADDR_W-1:0] ram_addr,
  output logic [TGM_ADDR_W-1:0] ram_nextaddr,
  output logic [TGM_BYTE_W-1:0] ram_data_in,
  input  logic [TGM_WORD_W-1:0] ram_data_out
);

  localparam logic [TGM_PTR_W-1:0] LAST = TGM_PTR_W'(FRAME_LEN - 1);

  tgm_state_t state_q, state_d;

  logic                  ptr_clr;
  logic                  in_fire;
  logic                  out_fire;
  logic                  load_word;
  logic [TGM_PTR_W-1:0]  wptr;
  logic [TGM_PTR_W-1:0]  rptr;
  logic [TGM_ADDR_W-1:0] waddr;
  logic [TGM_ADDR_W-1:0] raddr;

  tgm_addr_ctr #(.BASE_ADDR(BASE_ADDR)) u_wptr (
    .clk  (clk),
    .rst  (rst),
    .clr  (ptr_clr),
    .inc  (in_fire),
    .ptr  (wptr),
    .addr (waddr)
  );

  tgm_addr_ctr #(.BASE_ADDR(BASE_ADDR)) u_rptr (
    .clk  (clk),
    .rst  (rst),
    .clr  (ptr_clr),
    .inc  (out_fire),
    .ptr  (rptr),
    .addr (raddr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RAM read data is registered, so it is captured at the end of RD_WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
    end else if (load_word) begin
      out_data <= ram_data_out;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_clr      = 1'b0;
    in_fire      = 1'b0;
    out_fire     = 1'b0;
    load_word    = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    frame_done   = 1'b0;
    ram_wr       = 1'b0;
    ram_rd       = 1'b0;
    ram_addr     = '0;
    ram_nextaddr = '0;
    ram_data_in  = '0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          ptr_clr = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          in_fire      = 1'b1;
          ram_wr       = 1'b1;
          ram_nextaddr = waddr;
          ram_data_in  = in_data;
          if (wptr == LAST) begin
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        ram_rd   = 1'b1;
        ram_addr = raddr;
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        load_word = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          out_fire = 1'b1;
          state_d  = (rptr == LAST) ? DONE : RD_REQ;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tgm_ram_seq.sv
// Drives three sequencer instances (short frame, wrapping base, full 256 sweep)
// against a registered-read RAM model and a queue-based frame reference.
module tb_tgm_ram_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start     [3];
  logic        in_valid  [3];
  logic        out_ready [3];
  logic [7:0]  in_data   [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        busy      [3];
  logic        frame_done[3];
  logic        ram_wr    [3];
  logic        ram_rd    [3];
  logic [31:0] out_data  [3];
  logic [31:0] ram_data_out[3];
  logic [7:0]  ram_addr  [3];
  logic [7:0]  ram_nextaddr[3];
  logic [7:0]  ram_data_in[3];

  int checks = 0;
  int errors = 0;

  tgm_ram_seq #(.FRAME_LEN(4), .BASE_ADDR(8'h00)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0]), .frame_done(frame_done[0]), .ram_wr(ram_wr[0]), .ram_rd(ram_rd[0]),
    .ram_addr(ram_addr[0]), .ram_nextaddr(ram_nextaddr[0]), .ram_data_in(ram_data_in[0]),
    .ram_data_out(ram_data_out[0]));

  tgm_ram_seq #(.FRAME_LEN(4), .BASE_ADDR(8'hFE)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1]), .frame_done(frame_done[1]), .ram_wr(ram_wr[1]), .ram_rd(ram_rd[1]),
    .ram_addr(ram_addr[1]), .ram_nextaddr(ram_nextaddr[1]), .ram_data_in(ram_data_in[1]),
    .ram_data_out(ram_data_out[1]));

  tgm_ram_seq #(.FRAME_LEN(256), .BASE_ADDR(8'h00)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .busy(busy[2]), .frame_done(frame_done[2]), .ram_wr(ram_wr[2]), .ram_rd(ram_rd[2]),
    .ram_addr(ram_addr[2]), .ram_nextaddr(ram_nextaddr[2]), .ram_data_in(ram_data_in[2]),
    .ram_data_out(ram_data_out[2]));

  // RAM model (byte written zero-extended, one-cycle registered read) plus bus logs.
  logic [31:0] mem [3][256];
  logic [31:0] rdq [3];
  logic [7:0]  wa_q [3][$];
  logic [7:0]  wd_q [3][$];
  logic [7:0]  ra_q [3][$];
  int          fd_cnt [3];
  int          ovl_cnt[3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      fd_cnt[k]  = 0;
      ovl_cnt[k] = 0;
      rdq[k]     = '0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ram_wr[k]) begin
        mem[k][ram_nextaddr[k]] <= {24'h0, ram_data_in[k]};
        wa_q[k].push_back(ram_nextaddr[k]);
        wd_q[k].push_back(ram_data_in[k]);
      end
      if (ram_rd[k]) begin
        rdq[k] <= mem[k][ram_addr[k]];
        ra_q[k].push_back(ram_addr[k]);
      end
      if (frame_done[k]) fd_cnt[k] <= fd_cnt[k] + 1;
      if (ram_wr[k] && ram_rd[k]) ovl_cnt[k] <= ovl_cnt[k] + 1;
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) ram_data_out[k] = rdq[k];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One frame on instance k. stall_idx: word index held off for 5 cycles (-1 none).
  // noise: start pulses during FILL and in_valid held once all bytes are offered.
  // fixed: bytes 1..n with back-to-back valid and ready; otherwise random data and pacing.
  task automatic run_frame(input int k, input int n, input logic [7:0] base,
                           input int stall_idx, input bit noise, input bit fixed,
                           input string tag);
    logic [7:0] bytes[$];
    int wb, rb, fb, ob, sent, got, cyc, rd_cyc, stall_left, budget;
    bit prev_ov, done;
    logic [7:0] ea;

    for (int i = 0; i < n; i++) bytes.push_back(fixed ? 8'(i + 1) : 8'($urandom));
    wb = wa_q[k].size(); rb = ra_q[k].size(); fb = fd_cnt[k]; ob = ovl_cnt[k];
    sent = 0; got = 0; cyc = 0; rd_cyc = -100; stall_left = -1; prev_ov = 0; done = 0;
    budget = 20 * n + 50;

    // start and a valid byte together: only start acts.
    @(negedge clk);
    start[k] = 1'b1; in_valid[k] = 1'b1; in_data[k] = bytes[0]; out_ready[k] = 1'b0;
    checks++;
    if (in_ready[k] !== 1'b0) begin
      errors++; $display("FAIL %s idle_in_ready got %b want 0", tag, in_ready[k]);
    end

    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start[k] = (noise && sent == 1) ? 1'b1 : 1'b0;
      if (sent < n) begin
        in_valid[k] = fixed ? 1'b1 : ($urandom_range(0, 3) != 0);
        in_data[k]  = bytes[sent];
      end else begin
        in_valid[k] = noise;
        in_data[k]  = 8'hEE;
      end
      if (in_valid[k] && in_ready[k]) sent++;

      if (out_valid[k]) begin
        checks++;
        if (in_ready[k] !== 1'b0) begin
          errors++; $display("FAIL %s in_ready_during_out got %b want 0", tag, in_ready[k]);
        end
      end

      if (ram_rd[k]) rd_cyc = cyc;
      if (out_valid[k] && !prev_ov) begin
        checks++;
        if (cyc - rd_cyc != 2) begin
          errors++; $display("FAIL %s rd_to_valid_latency got %0d want 2", tag, cyc - rd_cyc);
        end
      end

      if (out_valid[k] && got == stall_idx && stall_left < 0) stall_left = 5;
      if (stall_left > 0) begin
        out_ready[k] = 1'b0;
        stall_left--;
        checks++;
        if (out_valid[k] !== 1'b1 || out_data[k] !== {24'h0, bytes[got]} || ram_rd[k] !== 1'b0) begin
          errors++;
          $display("FAIL %s stall got valid=%b data=%h rd=%b want valid=1 data=%h rd=0",
                   tag, out_valid[k], out_data[k], ram_rd[k], {24'h0, bytes[got]});
        end
      end else begin
        out_ready[k] = fixed ? 1'b1 : ($urandom_range(0, 2) != 0);
      end

      if (out_valid[k] && out_ready[k]) begin
        checks++;
        if (got >= n || out_data[k] !== {24'h0, bytes[got]}) begin
          errors++;
          $display("FAIL %s out_word[%0d] got %h want %h", tag, got, out_data[k],
                   (got < n) ? {24'h0, bytes[got]} : 32'hx);
        end
        got++;
      end

      if (frame_done[k]) done = 1;
      prev_ov = out_valid[k];
    end

    start[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;

    checks++;
    if (!done || got != n || sent != n) begin
      errors++;
      $display("FAIL %s completion got done=%0d words=%0d bytes=%0d want done=1 words=%0d bytes=%0d",
               tag, done, got, sent, n, n);
    end

    @(negedge clk);
    checks++;
    if (frame_done[k] !== 1'b0 || busy[k] !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done got frame_done=%b busy=%b want 0 0", tag, frame_done[k], busy[k]);
    end

    checks++;
    if (wa_q[k].size() - wb != n || ra_q[k].size() - rb != n) begin
      errors++;
      $display("FAIL %s strobe_counts got wr=%0d rd=%0d want %0d", tag,
               wa_q[k].size() - wb, ra_q[k].size() - rb, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        ea = 8'(base + 8'(i));
        checks++;
        if (wa_q[k][wb + i] !== ea || wd_q[k][wb + i] !== bytes[i] || ra_q[k][rb + i] !== ea) begin
          errors++;
          $display("FAIL %s ram_access[%0d] got wa=%h wd=%h ra=%h want wa=%h wd=%h ra=%h", tag, i,
                   wa_q[k][wb + i], wd_q[k][wb + i], ra_q[k][rb + i], ea, bytes[i], ea);
        end
      end
    end

    checks++;
    if (fd_cnt[k] - fb != 1 || ovl_cnt[k] - ob != 0) begin
      errors++;
      $display("FAIL %s pulses got frame_done=%0d wr_rd_overlap=%0d want 1 0", tag,
               fd_cnt[k] - fb, ovl_cnt[k] - ob);
    end
  endtask

  task automatic check_reset_values(input int k, input string tag);
    checks++;
    if (busy[k] !== 1'b0 || in_ready[k] !== 1'b0 || out_valid[k] !== 1'b0 ||
        frame_done[k] !== 1'b0 || ram_wr[k] !== 1'b0 || ram_rd[k] !== 1'b0 ||
        ram_addr[k] !== 8'h00 || ram_nextaddr[k] !== 8'h00 || ram_data_in[k] !== 8'h00 ||
        out_data[k] !== 32'h0) begin
      errors++;
      $display("FAIL %s inst%0d got busy=%b rdy=%b ov=%b fd=%b wr=%b rd=%b a=%h na=%h di=%h od=%h want all 0",
               tag, k, busy[k], in_ready[k], out_valid[k], frame_done[k], ram_wr[k], ram_rd[k],
               ram_addr[k], ram_nextaddr[k], ram_data_in[k], out_data[k]);
    end
  endtask

  task automatic test_reset();
    #2;
    for (int k = 0; k < 3; k++) check_reset_values(k, "reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_frame(0, 4, 8'h00, -1, 1'b0, 1'b1, "basic");
  endtask

  task automatic test_backpressure();
    run_frame(0, 4, 8'h00, 1, 1'b0, 1'b1, "backpressure");
  endtask

  task automatic test_wrap();
    run_frame(1, 4, 8'hFE, -1, 1'b0, 1'b0, "wrap");
  endtask

  task automatic test_ignored_inputs();
    run_frame(0, 4, 8'h00, -1, 1'b1, 1'b0, "ignored_inputs");
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = 8'h5A;
    @(negedge clk);
    in_data[0] = 8'hC3;
    @(negedge clk);
    in_data[0] = 8'h77;
    #2 rst = 1'b1;
    #1 check_reset_values(0, "mid_reset");
    @(negedge clk);
    in_valid[0] = 1'b0;
    rst = 1'b0;
    run_frame(0, 4, 8'h00, -1, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) run_frame(1, 4, 8'hFE, f, 1'b0, 1'b0, "back_to_back");
  endtask

  task automatic test_full_sweep();
    run_frame(2, 256, 8'h00, 200, 1'b0, 1'b0, "full_sweep");
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_data[k] = 8'h00;
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_ignored_inputs();
    test_mid_reset();
    test_back_to_back();
    test_full_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
